// File: rtl/ldst_issue_ctrl.sv
// Load/store issue controller: allocates reservation-station entries to the
// dispatch slots and keeps them in a program-order queue. Ops issue in order
// from the head of the queue. After a mispredict, killed entries are walked
// back off the tail of the queue.
module ldst_issue_ctrl #(
    parameter int ENT_NUM = 4,
    parameter int ENT_SEL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    output logic               alloc_ok,
    output logic               we1,
    output logic               we2,
    output logic [ENT_SEL-1:0] waddr1,
    output logic [ENT_SEL-1:0] waddr2,
    input  logic [ENT_NUM-1:0] busyvec,
    input  logic [ENT_NUM-1:0] ready,
    input  logic               prmiss,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic               clearbusy,
    output logic [ENT_SEL-1:0] issueaddr,
    output logic [ENT_SEL:0]   qcount
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [ENT_SEL:0]   DEPTH   = (ENT_SEL+1)'(ENT_NUM);
    localparam logic [ENT_SEL-1:0] ONE_PTR = (ENT_SEL)'(1);
    localparam logic [ENT_SEL:0]   ONE_CNT = (ENT_SEL+1)'(1);

    state_e             state_r, state_nxt_s;
    logic [ENT_SEL-1:0] queue_r [ENT_NUM];
    logic [ENT_SEL-1:0] head_r, tail_r;
    logic [ENT_SEL:0]   count_r;
    logic [ENT_NUM-1:0] wpend_r, wpend_nxt_s;

    logic [ENT_NUM-1:0] free_s;
    logic [ENT_SEL:0]   free_cnt_s, need_s, space_s, push_cnt_s;
    logic [ENT_SEL-1:0] f0_s, f1_s, tail_m1_s, tail_p1_s, head_ent_s;
    logic               f0_found_s, f1_found_s;
    logic               run_s, grant_s, g_we1_s, g_we2_s, has_s;
    logic [ENT_SEL-1:0] g_wa1_s, g_wa2_s;
    logic               g_iss_s, g_clr_s, walk_s;

    // Free entries: not busy in the RS and not granted last cycle
    // (busyvec lags a grant by one cycle). Pick the two lowest and count them.
    always_comb begin
        free_s     = ~busyvec & ~wpend_r;
        f0_s       = '0;
        f1_s       = '0;
        f0_found_s = 1'b0;
        f1_found_s = 1'b0;
        free_cnt_s = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            free_cnt_s = free_cnt_s + (ENT_SEL+1)'(free_s[i]);
            if (free_s[i] && !f0_found_s) begin
                f0_s       = (ENT_SEL)'(i);
                f0_found_s = 1'b1;
            end else if (free_s[i] && !f1_found_s) begin
                f1_s       = (ENT_SEL)'(i);
                f1_found_s = 1'b1;
            end else begin
                f1_found_s = f1_found_s;
            end
        end
    end

    // Grant, issue and flush-walk decisions plus queue bookkeeping values.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        need_s     = (ENT_SEL+1)'(req1) + (ENT_SEL+1)'(req2);
        space_s    = DEPTH - count_r;
        grant_s    = run_s && !prmiss && (free_cnt_s >= need_s) && (space_s >= need_s);
        g_we1_s    = req1 && grant_s;
        g_we2_s    = req2 && grant_s;
        g_wa1_s    = f0_s;
        g_wa2_s    = req1 ? f1_s : f0_s;
        has_s      = (count_r != '0);
        head_ent_s = queue_r[head_r];
        g_iss_s    = run_s && !prmiss && has_s && ready[head_ent_s];
        g_clr_s    = g_iss_s && iss_ready;
        tail_m1_s  = tail_r - ONE_PTR;
        tail_p1_s  = tail_r + (ENT_SEL)'(g_we1_s);
        walk_s     = !run_s && has_s && !busyvec[queue_r[tail_m1_s]];
        push_cnt_s = (ENT_SEL+1)'(g_we1_s) + (ENT_SEL+1)'(g_we2_s);
        wpend_nxt_s = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            wpend_nxt_s[i] = (g_we1_s && (g_wa1_s == (ENT_SEL)'(i))) ||
                             (g_we2_s && (g_wa2_s == (ENT_SEL)'(i)));
        end
    end

    // RUN/FLUSH next state: a mispredict starts (or prolongs) the walk.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (prmiss) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (walk_s || prmiss) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Control state: pointers, occupancy, pending grants and FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_RUN;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            wpend_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            wpend_r <= wpend_nxt_s;
            if (walk_s) begin
                tail_r  <= tail_m1_s;
                count_r <= count_r - ONE_CNT;
            end else begin
                tail_r  <= tail_r + push_cnt_s[ENT_SEL-1:0];
                count_r <= count_r + push_cnt_s - (ENT_SEL+1)'(g_clr_s);
            end
            head_r <= head_r + (ENT_SEL)'(g_clr_s);
        end
    end

    // Queue storage: slot 1 entry goes in first, slot 2 right behind it.
    always_ff @(posedge clk) begin
        if (reset && g_we1_s) begin
            queue_r[tail_r] <= g_wa1_s;
        end
        if (reset && g_we2_s) begin
            queue_r[tail_p1_s] <= g_wa2_s;
        end
    end

    // Outputs are forced to zero while reset is held low.
    always_comb begin
        if (!reset) begin
            alloc_ok  = 1'b0;
            we1       = 1'b0;
            we2       = 1'b0;
            waddr1    = '0;
            waddr2    = '0;
            iss_valid = 1'b0;
            clearbusy = 1'b0;
            issueaddr = '0;
            qcount    = '0;
        end else begin
            alloc_ok  = grant_s;
            we1       = g_we1_s;
            we2       = g_we2_s;
            waddr1    = g_wa1_s;
            waddr2    = g_wa2_s;
            iss_valid = g_iss_s;
            clearbusy = g_clr_s;
            issueaddr = has_s ? head_ent_s : '0;
            qcount    = count_r;
        end
    end

endmodule

// File: tb/tb_ldst_issue_ctrl.sv
// Directed table-driven bench for ldst_issue_ctrl, plus reset sequences.
module tb_ldst_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1, req2, prmiss, iss_ready;
    logic [3:0] busyvec, ready;
    logic       alloc_ok, we1, we2, iss_valid, clearbusy;
    logic [1:0] waddr1, waddr2, issueaddr;
    logic [2:0] qcount;

    int checks = 0;
    int errors = 0;

    ldst_issue_ctrl #(.ENT_NUM(4), .ENT_SEL(2)) dut (
        .clk(clk), .reset(reset), .req1(req1), .req2(req2),
        .alloc_ok(alloc_ok), .we1(we1), .we2(we2),
        .waddr1(waddr1), .waddr2(waddr2),
        .busyvec(busyvec), .ready(ready), .prmiss(prmiss),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .clearbusy(clearbusy), .issueaddr(issueaddr), .qcount(qcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req1, req2;
        logic [3:0] busy, rdy;
        logic       prm, irdy;
        logic       e_ok, e_we1, e_we2;
        logic       chk_wa;
        logic [1:0] e_wa1, e_wa2;
        logic       e_iv, e_cb;
        logic [1:0] e_ia;
        logic [2:0] e_qc;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic [3:0] b,
                         input logic [3:0] rd, input logic pm, input logic ir);
        req1 = r1; req2 = r2; busyvec = b; ready = rd; prmiss = pm; iss_ready = ir;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alloc_ok"},  int'(alloc_ok),  0);
        check({tag, ".we1"},       int'(we1),       0);
        check({tag, ".we2"},       int'(we2),       0);
        check({tag, ".waddr1"},    int'(waddr1),    0);
        check({tag, ".waddr2"},    int'(waddr2),    0);
        check({tag, ".iss_valid"}, int'(iss_valid), 0);
        check({tag, ".clearbusy"}, int'(clearbusy), 0);
        check({tag, ".issueaddr"}, int'(issueaddr), 0);
        check({tag, ".qcount"},    int'(qcount),    0);
    endtask

    task automatic check_vec(input int i);
        string t;
        t = $sformatf("v%0d", i);
        check({t, ".alloc_ok"},  int'(alloc_ok),  int'(vecs[i].e_ok));
        check({t, ".we1"},       int'(we1),       int'(vecs[i].e_we1));
        check({t, ".we2"},       int'(we2),       int'(vecs[i].e_we2));
        if (vecs[i].chk_wa) begin
            check({t, ".waddr1"}, int'(waddr1), int'(vecs[i].e_wa1));
            check({t, ".waddr2"}, int'(waddr2), int'(vecs[i].e_wa2));
        end
        check({t, ".iss_valid"}, int'(iss_valid), int'(vecs[i].e_iv));
        check({t, ".clearbusy"}, int'(clearbusy), int'(vecs[i].e_cb));
        check({t, ".issueaddr"}, int'(issueaddr), int'(vecs[i].e_ia));
        check({t, ".qcount"},    int'(qcount),    int'(vecs[i].e_qc));
    endtask

    initial begin
        //            r1    r2    busy     rdy      prm   irdy   ok    we1   we2   chk   wa1    wa2    iv    cb    ia     qc
        // fill an empty queue; second pair relies on the pending-grant mask
        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 2'd0, 3'd2};
        // queue full: refused even though entries 0,1 look free
        vecs[2]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 3'd4};
        // head 0 not ready while younger ones are; then head issues
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 3'd4};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 3'd4};
        // head 1 ready, memory stalls 3 cycles, then a single pop
        vecs[5]  = '{1'b0, 1'b0, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 3'd3};
        vecs[6]  = '{1'b0, 1'b0, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 3'd3};
        vecs[7]  = '{1'b0, 1'b0, 4'b1110, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 3'd3};
        vecs[8]  = '{1'b0, 1'b0, 4'b1110, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 2'd1, 3'd3};
        // single-slot grants, tail wraps
        vecs[9]  = '{1'b1, 1'b0, 4'b1100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd2, 3'd2};
        vecs[10] = '{1'b0, 1'b1, 4'b1100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 2'd2, 3'd3};
        // full queue: pop and request same cycle -> no grant; next cycle freed entry granted
        vecs[11] = '{1'b1, 1'b0, 4'b1111, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd2, 3'd4};
        vecs[12] = '{1'b0, 1'b1, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 2'd3, 3'd3};
        // queue [3,0,1,2]; mispredict keeps only entry 3
        vecs[13] = '{1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 3'd4};
        vecs[14] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd3, 3'd4};
        vecs[15] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd3, 3'd3};
        vecs[16] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd3, 3'd2};
        vecs[17] = '{1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd3, 3'd1};
        // back in RUN: head 3 offered, two new grants
        vecs[18] = '{1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd3, 3'd1};

        // reset held low: outputs zero regardless of inputs
        reset = 1'b0;
        drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            #2 check_zero($sformatf("rst%0d", c));
        end

        // table vectors, one per cycle
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            drive(vecs[i].req1, vecs[i].req2, vecs[i].busy, vecs[i].rdy,
                  vecs[i].prm, vecs[i].irdy);
            #2 check_vec(i);
        end

        // queue now [3,0,1]; mispredict, then reset in the middle of FLUSH
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 4'b1011, 4'b0000, 1'b1, 1'b0);
        #2 check("prm.qcount", int'(qcount), 3);
        check("prm.alloc_ok", int'(alloc_ok), 0);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1);
        #2 check("flush.qcount", int'(qcount), 3);
        check("flush.alloc_ok", int'(alloc_ok), 0);
        reset = 1'b0;
        #1 check_zero("midflush");
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
        #2 check_zero("held");
        @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        #2 check("post.alloc_ok", int'(alloc_ok), 1);
        check("post.we1", int'(we1), 1);
        check("post.we2", int'(we2), 1);
        check("post.waddr1", int'(waddr1), 0);
        check("post.waddr2", int'(waddr2), 1);
        check("post.qcount", int'(qcount), 0);
        check("post.iss_valid", int'(iss_valid), 0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldst_issue_ctrl.md
Name: ldst_issue_ctrl

Overview:
- Control partner of the load/store reservation station.
- Drives the RS allocation side (we1/we2, waddr1/waddr2) and its issue side (clearbusy, issueaddr) from the RS busy and ready vectors.
- Keeps a program-order queue of allocated entry indices so loads and stores issue strictly in order to the memory stage.
- On a branch mispredict, walks back over killed entries before allocation and issue resume.

Parameters:
- ENT_NUM, 4, number of RS entries (power of 2).
- ENT_SEL, 2, log2(ENT_NUM).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- req1  in  1  dispatch slot 1 requests a ldst entry.
- req2  in  1  dispatch slot 2 requests a ldst entry.
- alloc_ok  out  1  all current requests can be granted this cycle.
- we1  out  1  write RS entry waddr1 (slot 1 op).
- we2  out  1  write RS entry waddr2 (slot 2 op).
- waddr1  out  ENT_SEL  entry for slot 1.
- waddr2  out  ENT_SEL  entry for slot 2.
- busyvec  in  ENT_NUM  RS busy bits (registered in RS).
- ready  in  ENT_NUM  RS per-entry operands-ready.
- prmiss  in  1  branch mispredict this cycle.
- iss_valid  out  1  head op offered to memory stage.
- iss_ready  in  1  memory stage accepts.
- clearbusy  out  1  issue fires; RS clears busy[issueaddr].
- issueaddr  out  ENT_SEL  RS entry being read/issued.
- qcount  out  ENT_SEL+1  queue occupancy (debug/verif).

Behaviour:
- State: queue[ENT_NUM] of ENT_SEL-bit indices; head, tail (ENT_SEL bits, wrap modulo ENT_NUM); count (0..ENT_NUM); fsm in {RUN, FLUSH}.
- Reset (reset==0 at posedge): head=tail=count=0, fsm=RUN.
  - While reset==0, all outputs are 0 (alloc_ok, we1, we2, waddr1, waddr2, iss_valid, clearbusy, issueaddr, qcount).
- Free vector: free = ~busyvec & ~wpend.
  - wpend is a register holding the entries granted last cycle. It covers the one-cycle lag before busyvec reflects a grant.
- Entry selection:
  - f0 = lowest-indexed free entry; f1 = next-lowest.
  - waddr1 = f0.
  - waddr2 = f1 if req1, else f0.
- Grant condition: alloc_ok = fsm==RUN & ~prmiss & popcount(free) >= req1+req2 & (ENT_NUM-count) >= req1+req2.
  - alloc_ok=1 when req1=req2=0 and RUN & ~prmiss.
- Grant outputs: we1 = req1 & alloc_ok; we2 = req2 & alloc_ok.
  - Grants are all-or-nothing; there are no partial grants.
- Queue push, same posedge as the grant: waddr1 pushed first, then waddr2. tail += we1+we2.
- Issue:
  - H = queue[head]; issueaddr = H whenever count>0, else 0.
  - iss_valid = fsm==RUN & ~prmiss & count>0 & ready[H].
  - clearbusy = iss_valid & iss_ready. On clearbusy, head++ and count--.
  - Issue latency from ready[H] rising to iss_valid is 0 cycles (combinational).
  - Only the head may issue; a ready younger entry waits.
- Simultaneous push and pop: count += (we1+we2) - clearbusy.
  - When full, a pop does not free a slot in the same cycle; alloc uses the pre-pop count.
- Mispredict:
  - prmiss=1 suppresses grants and issue that cycle. Next state = FLUSH; wpend cleared.
  - Killed entries always form a suffix of the queue (youngest).
- FLUSH, each cycle, with busyvec already updated by the RS:
  - If count>0 and busyvec[queue[tail-1]]==0: tail--, count--, stay in FLUSH.
  - Otherwise go to RUN.
  - FLUSH takes at most ENT_NUM+1 cycles.
  - alloc_ok=0 and iss_valid=0 throughout FLUSH.
- prmiss during FLUSH: remain in FLUSH and continue the walk.
- Wrap-around: head and tail wrap naturally. count distinguishes full from empty when head==tail.

Test Plan:
- Reset, then req1=req2=1 with busyvec=0 -> waddr1=0, waddr2=1, we1=we2=1. Next cycle req1=req2=1 -> waddr1=2, waddr2=3 (wpend masks 0,1). Following cycle -> alloc_ok=0, qcount=4.
- Queue holds [0,1,2], ready=4'b0110 -> iss_valid=0 (head 0 not ready). Then ready[0]=1, iss_ready=1 -> clearbusy=1, issueaddr=0, qcount 3->2.
- Head ready with iss_ready=0 for 3 cycles -> iss_valid held at 1, clearbusy=0, issueaddr stable. iss_ready=1 -> single pop.
- Queue [1,2,3,0], pulse prmiss with busyvec becoming 4'b0010 (only entry 1 survives) -> 3 FLUSH cycles popping 0,3,2 from the tail, then RUN with qcount=1 and head=1. alloc_ok=0 throughout.
- Full queue, head ready, iss_ready=1, req1=1 in the same cycle -> clearbusy=1, alloc_ok=0. Next cycle alloc_ok=1 and the freed entry is granted.
- Drive reset=0 mid-FLUSH with qcount=3 -> next cycle qcount=0, fsm RUN, all outputs 0 while reset is held low.
